// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and message-length helper.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] PROG_CHG = 4'hC;
   localparam logic [3:0] CH_PRESS = 4'hD;

   localparam int unsigned NOTE_MIN = 21;
   localparam int unsigned NOTE_MAX = 108;

   localparam logic [7:0] RT_MIN  = 8'hF8;
   localparam logic [7:0] SYS_MIN = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2
   } state_e;

   // Channel messages carrying a single data byte.
   function automatic logic is_one_data(input logic [3:0] msg_type);
      return (msg_type == PROG_CHG) || (msg_type == CH_PRESS);
   endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note parser: byte stream in, last-note-priority voice out.
import midi_pkg::*;

module midi_note_decoder #(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       en,
   output logic [6:0] freq,
   output logic [6:0] velocity,
   output logic       note_evt
);

   state_e     state;
   logic       rs_valid;
   logic [3:0] rs_type;
   logic [3:0] rs_chan;
   logic [6:0] d1;

   logic       is_rt_c;
   logic       is_sys_c;
   logic       chan_ok_c;
   logic       range_ok_c;
   logic [6:0] note_idx_c;

   // Byte classification and completion qualifiers for the pending message.
   always_comb begin
      is_rt_c    = 1'b0;
      is_sys_c   = 1'b0;
      chan_ok_c  = 1'b0;
      range_ok_c = 1'b0;
      note_idx_c = 7'd0;

      is_rt_c    = (rx_byte >= RT_MIN);
      is_sys_c   = (rx_byte >= SYS_MIN) && !is_rt_c;
      chan_ok_c  = OMNI || (rs_chan == CHANNEL);
      range_ok_c = (d1 >= 7'(NOTE_MIN)) && (d1 <= 7'(NOTE_MAX));
      // Only consumed when range_ok_c holds, so the subtraction never wraps.
      note_idx_c = d1 - 7'(NOTE_MIN);
   end

   // Parser FSM, running status and voice register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rs_valid <= 1'b0;
         rs_type  <= 4'd0;
         rs_chan  <= 4'd0;
         d1       <= 7'd0;
         en       <= 1'b0;
         freq     <= 7'd0;
         velocity <= 7'd0;
         note_evt <= 1'b0;
      end else begin
         note_evt <= 1'b0;
         // Real-time bytes fall through untouched.
         if (rx_valid && !is_rt_c) begin
            if (is_sys_c) begin
               rs_valid <= 1'b0;
               state    <= IDLE;
            end else if (rx_byte[7]) begin
               rs_type  <= rx_byte[7:4];
               rs_chan  <= rx_byte[3:0];
               rs_valid <= 1'b1;
               state    <= WAIT_D1;
            end else begin
               case (state)
                  IDLE, WAIT_D1: begin
                     if ((state == WAIT_D1) || rs_valid) begin
                        if (is_one_data(rs_type)) begin
                           state <= IDLE;
                        end else begin
                           d1    <= rx_byte[6:0];
                           state <= WAIT_D2;
                        end
                     end
                  end
                  WAIT_D2: begin
                     state <= IDLE;
                     if (chan_ok_c && range_ok_c) begin
                        if ((rs_type == NOTE_ON) && (rx_byte[6:0] != 7'd0)) begin
                           freq     <= note_idx_c;
                           velocity <= rx_byte[6:0];
                           en       <= 1'b1;
                           note_evt <= 1'b1;
                        end else if (((rs_type == NOTE_OFF) || (rs_type == NOTE_ON)) &&
                                     en && (note_idx_c == freq)) begin
                           en       <= 1'b0;
                           note_evt <= 1'b1;
                        end
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder; main DUT on channel 0, second DUT in omni mode.
`timescale 1ns/1ps
module tb_midi_note_decoder;

   logic       clk;
   logic       reset;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       en, en2;
   logic [6:0] freq, freq2;
   logic [6:0] velocity, velocity2;
   logic       note_evt, note_evt2;

   int total;
   int bad;

   midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .en(en), .freq(freq), .velocity(velocity), .note_evt(note_evt)
   );

   midi_note_decoder #(.CHANNEL(4'd5), .OMNI(1'b1)) dut_omni (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .en(en2), .freq(freq2), .velocity(velocity2), .note_evt(note_evt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed voice as {en, freq, velocity, note_evt}.
   function automatic logic [15:0] obs();
      return {en, freq, velocity, note_evt};
   endfunction

   function automatic logic [15:0] pk(input logic e, input int unsigned f,
                                      input int unsigned v, input logic ev);
      return {e, 7'(f), 7'(v), ev};
   endfunction

   // One byte per cycle; returns #1 after the sampling edge.
   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs() !== 16'h0000) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", obs(), 16'h0000);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_cycle();
   endtask

   task automatic test_note_on();
      send(8'h90); send(8'h45); send(8'h64);
      total++;
      if (obs() !== pk(1, 48, 100, 1)) begin
         bad++; $display("FAIL note_on got=%h exp=%h", obs(), pk(1, 48, 100, 1));
      end
      idle_cycle();
      total++;
      if (obs() !== pk(1, 48, 100, 0)) begin
         bad++; $display("FAIL note_on_evt_pulse got=%h exp=%h", obs(), pk(1, 48, 100, 0));
      end
   endtask

   task automatic test_running_status();
      send(8'h48);
      total++;
      if (obs() !== pk(1, 48, 100, 0)) begin
         bad++; $display("FAIL rs_mid got=%h exp=%h", obs(), pk(1, 48, 100, 0));
      end
      send(8'h50);
      total++;
      if (obs() !== pk(1, 51, 80, 1)) begin
         bad++; $display("FAIL rs_note_on got=%h exp=%h", obs(), pk(1, 51, 80, 1));
      end
      send(8'h48); send(8'h00);
      total++;
      if (obs() !== pk(0, 51, 80, 1)) begin
         bad++; $display("FAIL rs_vel0_off got=%h exp=%h", obs(), pk(0, 51, 80, 1));
      end
   endtask

   task automatic test_note_off_other();
      send(8'h90); send(8'h45); send(8'h40);
      total++;
      if (obs() !== pk(1, 48, 64, 1)) begin
         bad++; $display("FAIL off_setup got=%h exp=%h", obs(), pk(1, 48, 64, 1));
      end
      send(8'h80); send(8'h40); send(8'h00);
      total++;
      if (obs() !== pk(1, 48, 64, 0)) begin
         bad++; $display("FAIL off_other_note got=%h exp=%h", obs(), pk(1, 48, 64, 0));
      end
      send(8'h80); send(8'h45); send(8'h40);
      total++;
      if (obs() !== pk(0, 48, 64, 1)) begin
         bad++; $display("FAIL off_match got=%h exp=%h", obs(), pk(0, 48, 64, 1));
      end
      // Off again while gate already closed: no event.
      send(8'h45); send(8'h40);
      total++;
      if (obs() !== pk(0, 48, 64, 0)) begin
         bad++; $display("FAIL off_when_idle got=%h exp=%h", obs(), pk(0, 48, 64, 0));
      end
   endtask

   task automatic test_realtime_filter();
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h7F);
      total++;
      if (obs() !== pk(1, 39, 127, 1)) begin
         bad++; $display("FAIL realtime_interleave got=%h exp=%h", obs(), pk(1, 39, 127, 1));
      end
      send(8'h91); send(8'h40); send(8'h40);
      total++;
      if (obs() !== pk(1, 39, 127, 0)) begin
         bad++; $display("FAIL other_channel got=%h exp=%h", obs(), pk(1, 39, 127, 0));
      end
      total++;
      if ({en2, freq2, velocity2, note_evt2} !== pk(1, 43, 64, 1)) begin
         bad++; $display("FAIL omni_channel got=%h exp=%h",
                         {en2, freq2, velocity2, note_evt2}, pk(1, 43, 64, 1));
      end
      send(8'h90); send(8'h10); send(8'h40);
      total++;
      if (obs() !== pk(1, 39, 127, 0)) begin
         bad++; $display("FAIL out_of_range_low got=%h exp=%h", obs(), pk(1, 39, 127, 0));
      end
      send(8'h6C); send(8'h01);
      total++;
      if (obs() !== pk(1, 87, 1, 1)) begin
         bad++; $display("FAIL range_max got=%h exp=%h", obs(), pk(1, 87, 1, 1));
      end
      send(8'h15); send(8'h02);
      total++;
      if (obs() !== pk(1, 0, 2, 1)) begin
         bad++; $display("FAIL range_min got=%h exp=%h", obs(), pk(1, 0, 2, 1));
      end
      send(8'h6D); send(8'h05);
      total++;
      if (obs() !== pk(1, 0, 2, 0)) begin
         bad++; $display("FAIL range_109 got=%h exp=%h", obs(), pk(1, 0, 2, 0));
      end
      send(8'h14); send(8'h05);
      total++;
      if (obs() !== pk(1, 0, 2, 0)) begin
         bad++; $display("FAIL range_20 got=%h exp=%h", obs(), pk(1, 0, 2, 0));
      end
   endtask

   task automatic test_skip();
      send(8'hC0); send(8'h05);
      total++;
      if (obs() !== pk(1, 0, 2, 0)) begin
         bad++; $display("FAIL prog_change got=%h exp=%h", obs(), pk(1, 0, 2, 0));
      end
      send(8'h90); send(8'h30); send(8'h20);
      total++;
      if (obs() !== pk(1, 27, 32, 1)) begin
         bad++; $display("FAIL after_prog_change got=%h exp=%h", obs(), pk(1, 27, 32, 1));
      end
      send(8'hF0); send(8'h45); send(8'h64);
      total++;
      if (obs() !== pk(1, 27, 32, 0)) begin
         bad++; $display("FAIL sysex_skip got=%h exp=%h", obs(), pk(1, 27, 32, 0));
      end
      send(8'hF7); send(8'h45); send(8'h64);
      total++;
      if (obs() !== pk(1, 27, 32, 0)) begin
         bad++; $display("FAIL rs_cleared got=%h exp=%h", obs(), pk(1, 27, 32, 0));
      end
   endtask

   task automatic test_abort_and_retrigger();
      send(8'h90); send(8'h40); send(8'h80); send(8'h30);
      total++;
      if (obs() !== pk(1, 27, 32, 0)) begin
         bad++; $display("FAIL abort_wait_d2 got=%h exp=%h", obs(), pk(1, 27, 32, 0));
      end
      send(8'h00);
      total++;
      if (obs() !== pk(0, 27, 32, 1)) begin
         bad++; $display("FAIL abort_new_status got=%h exp=%h", obs(), pk(0, 27, 32, 1));
      end
      send(8'h90); send(8'h30); send(8'h20);
      send(8'h30); send(8'h21);
      total++;
      if (obs() !== pk(1, 27, 33, 1)) begin
         bad++; $display("FAIL retrigger got=%h exp=%h", obs(), pk(1, 27, 33, 1));
      end
   endtask

   task automatic test_reset_mid();
      send(8'h90); send(8'h45);
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (obs() !== 16'h0000) begin
         bad++; $display("FAIL async_reset got=%h exp=%h", obs(), 16'h0000);
      end
      #17;
      reset = 1'b1;
      idle_cycle();
      send(8'h64);
      total++;
      if (obs() !== 16'h0000) begin
         bad++; $display("FAIL orphan_data got=%h exp=%h", obs(), 16'h0000);
      end
      send(8'h90); send(8'h45); send(8'h64);
      total++;
      if (obs() !== pk(1, 48, 100, 1)) begin
         bad++; $display("FAIL post_reset_note got=%h exp=%h", obs(), pk(1, 48, 100, 1));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_note_on();
      test_running_status();
      test_note_off_other();
      test_realtime_filter();
      test_skip();
      test_abort_and_retrigger();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/midi_note_decoder.md
Name: midi_note_decoder

Overview:
- Parses a byte stream from the MIDI UART receiver into a monophonic note command for the oscillator.
- Drives the oscillator `freq` (note index = MIDI note − 21, 0..87) and `en` (gate), plus note velocity.
- Handles running status, channel filtering, interleaved real-time bytes and skipping of non-note messages.
- Last-note priority: a new Note On replaces the current note.

Parameters:
- CHANNEL, 4'd0, MIDI channel accepted; low nibble of the status byte.
- OMNI, 1'b0, when 1 accept all channels and ignore CHANNEL.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_byte  input  8  received MIDI byte.
- rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
- en  output  1  gate to oscillator; 1 while a note is held.
- freq  output  7  note index, MIDI note − 21.
- velocity  output  7  velocity of the current note.
- note_evt  output  1  one-cycle pulse whenever en/freq/velocity change due to a message.

Behaviour:
- Reset (reset=0, async):
  - en=0, freq=0, velocity=0, note_evt=0.
  - FSM=IDLE, running status cleared.
  - A partial message in flight is discarded; the next data byte without a status byte is ignored.
- Bytes are consumed only in cycles with rx_valid=1; all other cycles hold state.
- Real-time bytes (0xF8–0xFF) are ignored entirely: no change to FSM, running status or data already captured.
- System common/exclusive (0xF0–0xF7) clears running status, FSM→IDLE; following data bytes are ignored until a new channel status arrives.
- Channel status byte (0x80–0xEF):
  - Latches running status (type + channel), FSM→WAIT_D1.
  - An earlier incomplete message is abandoned.
- FSM states:
  - IDLE: a data byte with running status valid is treated as D1 → WAIT_D2 or DONE per message length. A data byte without running status is ignored.
  - WAIT_D1: data byte latched as D1. Message types 0xC/0xD (1 data byte) complete here; all others go to WAIT_D2.
  - WAIT_D2: data byte latched as D2. The message completes and FSM→IDLE with running status retained.
- A completing message acts only if all of the following hold:
  - type is 0x9 (Note On) or 0x8 (Note Off);
  - channel matches, or OMNI=1;
  - 21 ≤ D1 ≤ 108.
  - Otherwise no output change and no note_evt.
- Note On with D2≠0:
  - freq=D1−21, velocity=D2, en=1, note_evt=1.
  - Applies even if the same note is already held (retrigger).
- Note Off, or Note On with D2=0:
  - If en=1 and D1−21==freq: en=0, note_evt=1; freq and velocity are held.
  - Otherwise ignored.
- Latency: outputs update on the clock edge at which the completing data byte is sampled, i.e. visible the cycle after that rx_valid; note_evt is high exactly that one cycle.
- Width rule: freq = D1[6:0] − 7'd21, computed only after the range check, so it never wraps.
- A status byte arriving while in WAIT_D2 aborts the pending message; the new status takes effect.

Decomposition:
- Shared package midi_pkg:
  - status type constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG_CHG=4'hC, CH_PRESS=4'hD;
  - NOTE_MIN=21, NOTE_MAX=108, RT_MIN=8'hF8;
  - FSM enum {IDLE, WAIT_D1, WAIT_D2}.
- No sub-module: parser FSM and voice register live in this module. The codebase Counter/MagComp are not needed; range checks are inline comparisons.

Test Plan:
- Bytes 0x90,0x45,0x64 → one cycle after the last byte: en=1, freq=48, velocity=100, note_evt=1 for one cycle.
- Running status: after above, 0x48,0x50 → freq=51, velocity=80, en=1. Then 0x48,0x00 → en=0, freq stays 51.
- Note Off for other note: hold note 0x45 (freq=48), send 0x80,0x40,0x00 → no change, no note_evt. Then 0x80,0x45,0x40 → en=0.
- Interleaved real-time and filtering (CHANNEL=0, OMNI=0):
  - 0x90,0xF8,0x3C,0xFE,0x7F → freq=39, velocity=127, en=1.
  - 0x91,0x40,0x40 → ignored.
  - Out-of-range 0x90,0x10,0x40 → ignored.
- Skipping: 0xC0,0x05 then 0x90,0x30,0x20 → program change ignored; note sets freq=27. Also 0xF0,0x45,0x64 → ignored, running status cleared.
- Reset mid-message: 0x90,0x45, assert reset low for 2 cycles asynchronously between clock edges → outputs 0 immediately. After release, 0x64 alone → ignored, en stays 0.
